// File: rtl/spi_reg_slave.sv
// SPI slave with a 128 x 32-bit register file. Fixed 44-edge frames carry
// {SID, WRB, ADDR} and, for writes, 32 data bits; only a matching SID responds.
module spi_reg_slave #(
  parameter int SID_W  = 3,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic             SPI_CLK,
  input  logic             SPI_RST,
  input  logic [SID_W-1:0] SID_assign,
  input  logic             SPI_CS,
  input  logic             SPI_MOSI,
  output logic             SPI_MISO
);

  localparam int HDR_W = SID_W + 1 + ADDR_W;
  localparam int FRAME = 1 + HDR_W + DATA_W;
  localparam int CNT_W = $clog2(FRAME);

  // ctrl_cnt holds the number of edges already seen, so the edge being
  // processed is ctrl_cnt+1; the last header edge and last frame edge follow.
  localparam logic [CNT_W-1:0] CNT_DECODE = CNT_W'(HDR_W);
  localparam logic [CNT_W-1:0] CNT_END    = CNT_W'(FRAME - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_WDATA,
    ST_RDATA,
    ST_IGNORE
  } state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    ctrl_cnt, cnt_next;
  logic [HDR_W-1:0]    header, hdr_next, hdr_shift;
  logic [DATA_W-1:0]   shift_data, data_next, data_shift;
  logic [DATA_W-1:0]   regs [2**ADDR_W];
  logic                miso_next;
  logic                wr_en;

  // Valid/ready does not apply here: the master owns timing, and every
  // rising SPI_CLK edge with SPI_CS low is one accepted bit of the frame.
  always_comb begin
    state_next = state;
    cnt_next   = ctrl_cnt + CNT_ONE;
    hdr_next   = header;
    data_next  = shift_data;
    miso_next  = 1'b0;
    wr_en      = 1'b0;
    hdr_shift  = {header[HDR_W-2:0], SPI_MOSI};
    data_shift = {shift_data[DATA_W-2:0], SPI_MOSI};

    if (SPI_CS) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
      hdr_next   = '0;
    end else begin
      case (state)
        ST_IDLE: state_next = ST_HEADER;
        ST_HEADER: begin
          hdr_next = hdr_shift;
          if (ctrl_cnt == CNT_DECODE) begin
            if (hdr_shift[HDR_W-1 -: SID_W] != SID_assign) begin
              state_next = ST_IGNORE;
            end else if (hdr_shift[ADDR_W]) begin
              state_next = ST_WDATA;
            end else begin
              state_next = ST_RDATA;
              data_next  = regs[hdr_shift[ADDR_W-1:0]];
            end
          end
        end
        ST_WDATA: begin
          data_next = data_shift;
          // The captured SID re-qualifies the commit on the final edge.
          if (ctrl_cnt == CNT_END && header[HDR_W-1 -: SID_W] == SID_assign) begin
            wr_en = 1'b1;
          end
        end
        ST_RDATA: begin
          miso_next = shift_data[DATA_W-1];
          data_next = {shift_data[DATA_W-2:0], 1'b0};
        end
        ST_IGNORE: ;
        default: state_next = ST_IDLE;
      endcase

      if (ctrl_cnt == CNT_END) begin
        cnt_next   = '0;
        state_next = ST_IDLE;
      end
    end
  end

  always_ff @(posedge SPI_CLK) begin
    if (!SPI_RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge SPI_CLK) begin
    if (!SPI_RST) begin
      ctrl_cnt   <= '0;
      header     <= '0;
      shift_data <= '0;
      SPI_MISO   <= 1'b0;
      for (int i = 0; i < 2**ADDR_W; i++) begin
        regs[i] <= '0;
      end
    end else begin
      ctrl_cnt   <= cnt_next;
      header     <= hdr_next;
      shift_data <= data_next;
      SPI_MISO   <= miso_next;
      if (wr_en) begin
        regs[header[ADDR_W-1:0]] <= data_shift;
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: frame-level register model, per-edge MISO
// expectations through a queue, plus literal word checks.
module tb_spi_reg_slave;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 7;

  logic       spi_clk    = 1'b0;
  logic       spi_rst    = 1'b0;
  logic       spi_cs     = 1'b1;
  logic       spi_mosi   = 1'b0;
  logic [2:0] sid_assign = 3'b010;
  logic       spi_miso;

  int n_checks = 0;
  int n_errors = 0;

  logic [0:0]        exp_q[$];
  logic [DATA_W-1:0] model_regs [2**ADDR_W];
  logic [DATA_W-1:0] w;
  logic              m;

  spi_reg_slave dut (
    .SPI_CLK    (spi_clk),
    .SPI_RST    (spi_rst),
    .SID_assign (sid_assign),
    .SPI_CS     (spi_cs),
    .SPI_MOSI   (spi_mosi),
    .SPI_MISO   (spi_miso)
  );

  // ---------------- clock ----------------
  always #5 spi_clk = ~spi_clk;

  // ---------------- checks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic summary();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
  endtask

  // Scoreboard: one expected MISO value per rising edge, compared 1 time unit after it.
  initial begin
    logic [0:0] e;
    forever begin
      @(posedge spi_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (spi_miso !== e[0]) begin
          n_errors++;
          $display("FAIL miso_edge t=%0t: got %b expected %b", $time, spi_miso, e[0]);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick(input logic rst, input logic cs, input logic mosi,
                      input logic exp, output logic miso_s);
    @(negedge spi_clk);
    spi_rst  = rst;
    spi_cs   = cs;
    spi_mosi = mosi;
    exp_q.push_back(exp);
    @(posedge spi_clk);
    #1;
    miso_s = spi_miso;
  endtask

  task automatic gap();
    logic s;
    tick(1'b1, 1'b1, 1'b0, 1'b0, s);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2**ADDR_W; i++) model_regs[i] = '0;
  endtask

  task automatic do_reset(input int n);
    logic s;
    for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, s);
    clear_model();
  endtask

  // Drives edges 1..n_edges of a frame; the model decides MISO per edge and
  // commits a write only for a complete, selected write frame.
  task automatic frame(input logic [2:0] sid, input logic wrb, input logic [6:0] addr,
                       input logic [31:0] data, input int n_edges, output logic [31:0] word);
    logic [10:0] hdr;
    logic        sel, mosi, exp, s;
    hdr  = {sid, wrb, addr};
    sel  = (sid == sid_assign);
    word = '0;
    for (int k = 1; k <= n_edges; k++) begin
      exp = 1'b0;
      if (k == 1) begin
        mosi = 1'($urandom_range(0, 1));
      end else if (k <= 12) begin
        mosi = hdr[12-k];
      end else begin
        mosi = wrb ? data[44-k] : 1'($urandom_range(0, 1));
        if (!wrb && sel) exp = model_regs[addr][44-k];
      end
      tick(1'b1, 1'b0, mosi, exp, s);
      if (k >= 13) word[44-k] = s;
    end
    if (wrb && sel && n_edges == 44) model_regs[addr] = data;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_model();
    do_reset(10);
    check("reset_ctrl_cnt", 32'(dut.ctrl_cnt), 32'h0);
    check("reset_miso", 32'(spi_miso), 32'h0);
    gap();

    // 1: read after reset
    frame(3'b010, 1'b0, 7'd30, 32'h0, 44, w);
    check("t1_read_after_reset", w, 32'h0000_0000);
    check("t1_ctrl_cnt_after_edge44", 32'(dut.ctrl_cnt), 32'h0);
    gap();

    // 2: write then read back
    frame(3'b010, 1'b1, 7'd30, 32'h9234_5679, 44, w);
    gap();
    frame(3'b010, 1'b0, 7'd30, 32'h0, 44, w);
    check("t2_readback", w, 32'h9234_5679);
    gap();

    // 3: SID 111 is not us
    frame(3'b111, 1'b0, 7'd30, 32'h0, 44, w);
    check("t3_sid111_read", w, 32'h0000_0000);
    gap();
    frame(3'b010, 1'b0, 7'd30, 32'h0, 44, w);
    check("t3_readback", w, 32'h9234_5679);
    gap();

    // 4: mismatched write is ignored
    frame(3'b011, 1'b1, 7'd30, 32'hDEAD_BEEF, 44, w);
    gap();
    frame(3'b010, 1'b0, 7'd30, 32'h0, 44, w);
    check("t4_mismatch_write", w, 32'h9234_5679);
    gap();

    // 5: aborted write
    frame(3'b010, 1'b1, 7'd30, 32'h0BAD_F00D, 20, w);
    check("t5_ctrl_cnt_mid", 32'(dut.ctrl_cnt), 32'd20);
    gap();
    check("t5_ctrl_cnt_after_cs", 32'(dut.ctrl_cnt), 32'h0);
    frame(3'b010, 1'b0, 7'd30, 32'h0, 44, w);
    check("t5_abort_no_write", w, 32'h9234_5679);
    gap();

    // 6: address boundaries, back-to-back frames without a CS gap
    frame(3'b010, 1'b1, 7'd0, 32'hA5A5_A5A5, 44, w);
    frame(3'b010, 1'b1, 7'd127, 32'h5A5A_5A5A, 44, w);
    gap();
    frame(3'b010, 1'b0, 7'd0, 32'h0, 44, w);
    check("t6_addr0", w, 32'hA5A5_A5A5);
    frame(3'b010, 1'b0, 7'd127, 32'h0, 44, w);
    check("t6_addr127", w, 32'h5A5A_5A5A);
    gap();

    // 6b: reset in the middle of a read
    frame(3'b010, 1'b0, 7'd0, 32'h0, 20, w);
    check("t6_partial_read_top", 32'(w[31:24]), 32'h0000_00A5);
    tick(1'b0, 1'b0, 1'b1, 1'b0, m);
    clear_model();
    check("t6_rst_miso", 32'(m), 32'h0);
    check("t6_rst_ctrl_cnt", 32'(dut.ctrl_cnt), 32'h0);
    do_reset(2);
    gap();
    frame(3'b010, 1'b0, 7'd0, 32'h0, 44, w);
    check("t6_cleared_addr0", w, 32'h0);
    gap();
    frame(3'b010, 1'b0, 7'd127, 32'h0, 44, w);
    check("t6_cleared_addr127", w, 32'h0);
    gap();
    frame(3'b010, 1'b0, 7'd30, 32'h0, 44, w);
    check("t6_cleared_addr30", w, 32'h0);
    gap();

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge spi_clk);
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expected edges left unchecked", exp_q.size());
    end
    summary();
    $finish;
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    summary();
    $finish;
  end

endmodule
